// File: rtl/toggle_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : toggle_gen_pkg
//  Description : Shared state encoding and default parameters for the
//                multi-channel square-wave generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package toggle_gen_pkg;

    localparam int c_WIDTH_DEFAULT = 4;
    localparam int c_CNT_W_DEFAULT = 8;

    // Controller states, explicitly 2 bits wide
    typedef logic [1:0] state_t;

    localparam state_t c_IDLE   = 2'd0;
    localparam state_t c_RUN    = 2'd1;
    localparam state_t c_FINISH = 2'd2;

endpackage : toggle_gen_pkg
`default_nettype wire

// File: rtl/toggle_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : toggle_gen_if
//  Description : Control/status bundle between a stimulus owner (master) and
//                the square-wave generator (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface toggle_gen_if
    import toggle_gen_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT,
    parameter int CNT_W = c_CNT_W_DEFAULT
);
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] half_period;
    logic [CNT_W-1:0] num_toggles;
    logic [WIDTH-1:0] init;
    logic [WIDTH-1:0] en_mask;
    logic [WIDTH-1:0] pol;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] toggle_cnt;

    modport master (
        output start, stop, half_period, num_toggles, init, en_mask, pol,
        input  y, busy, done, toggle_cnt
    );

    modport slave (
        input  start, stop, half_period, num_toggles, init, en_mask, pol,
        output y, busy, done, toggle_cnt
    );

endinterface : toggle_gen_if
`default_nettype wire

// File: rtl/toggle_gen_tick_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tick_timer
//  Description : Half-period phase counter. Holds the latched half period
//                (a zero request is promoted to one) and flags the last
//                phase of each period with a combinational tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_timer #(
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic [CNT_W-1:0] hp_in,
    input  wire logic             clear,
    input  wire logic             en,
    output logic                  tick
);

    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_hp;
    logic [CNT_W-1:0] r_phase;
    logic [CNT_W-1:0] w_hp_eff;

    assign w_hp_eff = (hp_in == '0) ? c_ONE : hp_in;
    assign tick     = (r_phase == (r_hp - c_ONE));

    // Latch the period on load; advance or wrap the phase while enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hp    <= c_ONE;
            r_phase <= '0;
        end else begin
            if (load) begin
                r_hp <= w_hp_eff;
            end
            if (clear) begin
                r_phase <= '0;
            end else if (en) begin
                r_phase <= tick ? '0 : (r_phase + c_ONE);
            end
        end
    end

endmodule : tick_timer
`default_nettype wire

// File: rtl/toggle_gen.sv
`default_nettype none
// ============================================================================
//  Module      : toggle_gen
//  Description : Multi-channel square-wave generator. Each channel inverts a
//                registered level every half period for a counted number of
//                toggles or until stopped; outputs are polarity adjusted.
//  Revision    : 1.0 - initial release
// ============================================================================
module toggle_gen
    import toggle_gen_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT,
    parameter int CNT_W = c_CNT_W_DEFAULT
) (
    input  wire logic   clk,
    input  wire logic   rst,
    toggle_gen_if.slave bus
);

    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;
    logic             w_advance;
    logic             w_tick;
    logic             w_timer_en;
    logic [CNT_W-1:0] w_cnt_next;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_pol;
    logic [WIDTH-1:0] r_en;
    logic [CNT_W-1:0] r_nt;
    logic [CNT_W-1:0] r_cnt;

    assign w_cnt_next = r_cnt + c_ONE;
    // A stop in RUN freezes the phase along with everything else
    assign w_timer_en = (r_state == c_RUN) && !bus.stop;

    tick_timer #(
        .CNT_W (CNT_W)
    ) u_tick_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (w_accept),
        .hp_in (bus.half_period),
        .clear (w_accept),
        .en    (w_timer_en),
        .tick  (w_tick)
    );

    // Controller state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; stop takes priority over start and over a terminal tick
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (bus.start && !bus.stop) begin
                    w_accept     = 1'b1;
                    w_state_next = c_RUN;
                end
            end
            c_RUN: begin
                if (bus.stop) begin
                    w_state_next = c_IDLE;
                end else if (w_tick) begin
                    w_advance = 1'b1;
                    if ((r_nt != '0) && (w_cnt_next == r_nt)) begin
                        w_state_next = c_FINISH;
                    end
                end
            end
            c_FINISH: begin
                w_state_next = c_IDLE;
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // Channel levels, run configuration and toggle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= '0;
            r_pol <= '0;
            r_en  <= '0;
            r_nt  <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_q   <= bus.init;
            r_pol <= bus.pol;
            r_en  <= bus.en_mask;
            r_nt  <= bus.num_toggles;
            r_cnt <= '0;
        end else if (w_advance) begin
            r_q   <= r_q ^ r_en;
            r_cnt <= w_cnt_next;
        end
    end

    assign bus.y          = r_q ^ r_pol;
    assign bus.busy       = (r_state == c_RUN);
    assign bus.done       = (r_state == c_FINISH);
    assign bus.toggle_cnt = r_cnt;

endmodule : toggle_gen
`default_nettype wire

// File: tb/tb_toggle_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_toggle_gen
//  Description : Directed self-checking bench for toggle_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_toggle_gen;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    toggle_gen_if #(.WIDTH(4), .CNT_W(8)) bus_a ();
    toggle_gen_if #(.WIDTH(4), .CNT_W(4)) bus_b ();

    toggle_gen #(.WIDTH(4), .CNT_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    toggle_gen #(.WIDTH(4), .CNT_W(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1ns past the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a run request; returns 1ns after the sampling edge E0
    task automatic start_a(input logic [7:0] hp, input logic [7:0] nt,
                           input logic [3:0] ini, input logic [3:0] en,
                           input logic [3:0] pl);
        bus_a.half_period = hp;
        bus_a.num_toggles = nt;
        bus_a.init        = ini;
        bus_a.en_mask     = en;
        bus_a.pol         = pl;
        bus_a.start       = 1'b1;
        @(posedge clk);
        #1;
        bus_a.start       = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.half_period = '0;
        bus_a.num_toggles = '0; bus_a.init = '0; bus_a.en_mask = '0; bus_a.pol = '0;
        bus_b.start = 1'b0; bus_b.stop = 1'b0; bus_b.half_period = '0;
        bus_b.num_toggles = '0; bus_b.init = '0; bus_b.en_mask = '0; bus_b.pol = '0;
        step(2);
        rst = 1'b0;

        // Reset state
        check("rst_y",    bus_a.y, 4'h0);
        check("rst_busy", bus_a.busy, 1'b0);
        check("rst_done", bus_a.done, 1'b0);
        check("rst_cnt",  bus_a.toggle_cnt, 8'd0);

        // Counted run: hp=100, nt=10, all channels
        start_a(8'd100, 8'd10, 4'b0000, 4'b1111, 4'b0000);
        check("cnt_busy0", bus_a.busy, 1'b1);
        check("cnt_y0",    bus_a.y, 4'h0);
        step(99);
        check("cnt_y99",   bus_a.y, 4'h0);
        step(1);
        check("cnt_y100",  bus_a.y, 4'hF);
        check("cnt_c100",  bus_a.toggle_cnt, 8'd1);
        step(899);
        check("cnt_done999", bus_a.done, 1'b0);
        check("cnt_busy999", bus_a.busy, 1'b1);
        step(1);
        check("cnt_done1000", bus_a.done, 1'b1);
        check("cnt_busy1000", bus_a.busy, 1'b0);
        check("cnt_y1000",    bus_a.y, 4'h0);
        check("cnt_c1000",    bus_a.toggle_cnt, 8'd10);
        step(1);
        check("cnt_done1001", bus_a.done, 1'b0);
        check("cnt_busy1001", bus_a.busy, 1'b0);

        // Mask and polarity: hp=2, nt=3
        start_a(8'd2, 8'd3, 4'b0101, 4'b0011, 4'b1000);
        check("mp_y0", bus_a.y, 4'b1101);
        step(1);
        check("mp_y1", bus_a.y, 4'b1101);
        step(1);
        check("mp_y2", bus_a.y, 4'b1110);
        step(2);
        check("mp_y4", bus_a.y, 4'b1101);
        check("mp_done4", bus_a.done, 1'b0);
        step(2);
        check("mp_y6", bus_a.y, 4'b1110);
        check("mp_done6", bus_a.done, 1'b1);
        check("mp_cnt6", bus_a.toggle_cnt, 8'd3);
        step(1);
        check("mp_done7", bus_a.done, 1'b0);
        check("mp_y7", bus_a.y, 4'b1110);

        // Stop on the terminal cycle: hp=4, nt=2
        start_a(8'd4, 8'd2, 4'b0000, 4'b1111, 4'b0000);
        step(7);
        check("st_cnt7", bus_a.toggle_cnt, 8'd1);
        bus_a.stop = 1'b1;
        step(1);
        check("st_busy", bus_a.busy, 1'b0);
        check("st_done", bus_a.done, 1'b0);
        check("st_cnt",  bus_a.toggle_cnt, 8'd1);
        check("st_y",    bus_a.y, 4'hF);
        bus_a.stop = 1'b0;
        step(1);
        check("st_done_after", bus_a.done, 1'b0);

        // half_period=0 acts as 1; start during RUN is ignored
        start_a(8'd0, 8'd0, 4'b0000, 4'b0001, 4'b0000);
        check("hp0_y0", bus_a.y, 4'b0000);
        step(1);
        check("hp0_y1", bus_a.y, 4'b0001);
        step(1);
        check("hp0_y2", bus_a.y, 4'b0000);
        bus_a.start = 1'b1; bus_a.half_period = 8'd5; bus_a.init = 4'b1111;
        step(1);
        bus_a.start = 1'b0;
        check("rs_y3",   bus_a.y, 4'b0001);
        check("rs_cnt3", bus_a.toggle_cnt, 8'd3);
        bus_a.stop = 1'b1;
        step(1);
        bus_a.stop = 1'b0;
        check("rs_busy", bus_a.busy, 1'b0);
        check("rs_y4",   bus_a.y, 4'b0001);
        check("rs_cnt4", bus_a.toggle_cnt, 8'd3);

        // start and stop together in IDLE: no run
        bus_a.start = 1'b1; bus_a.stop = 1'b1; bus_a.init = 4'b1010;
        step(1);
        bus_a.start = 1'b0; bus_a.stop = 1'b0;
        check("ss_busy", bus_a.busy, 1'b0);
        check("ss_y",    bus_a.y, 4'b0001);
        check("ss_cnt",  bus_a.toggle_cnt, 8'd3);

        // Asynchronous reset mid-run: hp=3, nt=0
        start_a(8'd3, 8'd0, 4'b0110, 4'b1111, 4'b0000);
        step(9);
        check("ar_busy", bus_a.busy, 1'b1);
        check("ar_cnt",  bus_a.toggle_cnt, 8'd3);
        check("ar_y",    bus_a.y, 4'b1001);
        #2;
        rst = 1'b1;
        #1;
        check("ar_rst_y",    bus_a.y, 4'h0);
        check("ar_rst_busy", bus_a.busy, 1'b0);
        check("ar_rst_done", bus_a.done, 1'b0);
        check("ar_rst_cnt",  bus_a.toggle_cnt, 8'd0);
        #1;
        rst = 1'b0;
        step(1);

        // Free-running wrap on the 4-bit counter instance
        bus_b.half_period = 4'd1; bus_b.num_toggles = 4'd0; bus_b.init = 4'b0000;
        bus_b.en_mask = 4'b0001; bus_b.pol = 4'b0000; bus_b.start = 1'b1;
        step(1);
        bus_b.start = 1'b0;
        check("wr_cnt0",  bus_b.toggle_cnt, 4'd0);
        check("wr_busy0", bus_b.busy, 1'b1);
        for (int i = 0; i < 15; i++) begin
            step(1);
            check("wr_done_lo", bus_b.done, 1'b0);
        end
        check("wr_cnt15", bus_b.toggle_cnt, 4'd15);
        step(1);
        check("wr_cnt16",  bus_b.toggle_cnt, 4'd0);
        check("wr_busy16", bus_b.busy, 1'b1);
        check("wr_done16", bus_b.done, 1'b0);
        step(4);
        check("wr_cnt20",  bus_b.toggle_cnt, 4'd4);
        check("wr_busy20", bus_b.busy, 1'b1);
        bus_b.stop = 1'b1;
        step(1);
        bus_b.stop = 1'b0;
        check("wr_stop_busy", bus_b.busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_toggle_gen
`default_nettype wire
